// File: rtl/s2p_pkg.sv
// s2p_pkg: shared types and constants for the s2p_stream deserializer.
// Holds the FSM state enum and the parity-mode constant.
// Optional feature macro: S2P_PARITY_EN (adds the PAR state and even-parity check).
package s2p_pkg;

`ifdef S2P_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam bit PARITY_EN = 1'b1;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;

  localparam bit PARITY_EN = 1'b0;
`endif

endpackage

// File: rtl/s2p_outreg.sv
// s2p_outreg: single-entry output register with valid/ready handshake and overflow pulse.
// Latency: word visible 1 clk after in_vld_i. Backpressure: a word arriving while full
// and out_rdy_i=0 is dropped, the held word stays stable and ovf_o pulses for 1 clk.
// Ports: clk, rst (sync, active-high), in_vld_i/in_dat_i, out_dat_o/out_vld_o/out_rdy_i, ovf_o.
module s2p_outreg #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  output logic [W-1:0] out_dat_o,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output logic         ovf_o
);

  logic [W-1:0] dat_q, dat_d;
  logic         vld_q, vld_d;
  logic         ovf_q, ovf_d;
  logic         load;

  // Load when empty or when the held word leaves in this same cycle.
  assign load = in_vld_i && (!vld_q || out_rdy_i);

  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    ovf_d = 1'b0;
    if (load) begin
      dat_d = in_dat_i;
      vld_d = 1'b1;
    end else if (out_rdy_i) begin
      vld_d = 1'b0;
    end
    if (in_vld_i && vld_q && !out_rdy_i) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dat_q <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      vld_q <= vld_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_dat_o = dat_q;
  assign out_vld_o = vld_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/s2p_stream.sv
// s2p_stream: serial-to-parallel deserializer with start-of-frame alignment.
// Latency: dout_vld rises 1 clk after the last bit of a word. Backpressure: single output
// slot; a completed word meeting a full, stalled slot is dropped with an ovf pulse.
// Ports: clk, rst, din/din_vld/din_sof (serial in), dout/dout_vld/dout_rdy/dout_err (word out), ovf.
// Optional feature macro: S2P_PARITY_EN (one even-parity bit follows each WIDTH-bit word).
module s2p_stream
  import s2p_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             din_sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             dout_err,
  output logic             ovf
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_LSB = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  sr_q, sr_d;

  logic [CW-1:0]     idx;
  logic [WIDTH-1:0]  base, mask, sr_w;
  logic              cmp_vld;
  logic [WIDTH-1:0]  cmp_word;
  logic              cmp_err;

  logic [WIDTH-1:0]  out_word;
  logic              out_err;

  // A bit flagged with din_sof always becomes index 0 of a fresh word.
  assign idx  = din_sof ? '0 : cnt_q;
  assign base = din_sof ? '0 : sr_q;
  assign mask = LSB_FIRST ? (ONE_LSB << idx) : (ONE_MSB >> idx);
  assign sr_w = (base & ~mask) | (din ? mask : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    cmp_vld  = 1'b0;
    cmp_word = sr_q;
    cmp_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (din_vld && din_sof) begin
          sr_d    = sr_w;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (din_vld) begin
          sr_d = sr_w;
          if (!din_sof && cnt_q == LAST) begin
            cnt_d = '0;
`ifdef S2P_PARITY_EN
            state_d = PAR;
`else
            cmp_vld  = 1'b1;
            cmp_word = sr_w;
`endif
          end else begin
            cnt_d = idx + CW'(1);
          end
        end
      end
`ifdef S2P_PARITY_EN
      PAR: begin
        if (din_vld) begin
          state_d = SHIFT;
          if (din_sof) begin
            sr_d  = sr_w;
            cnt_d = CW'(1);
          end else begin
            // Even parity: XOR over data plus parity bit is 0 for a clean word.
            cmp_vld  = 1'b1;
            cmp_word = sr_q;
            cmp_err  = (^sr_q) ^ din;
            cnt_d    = '0;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  s2p_outreg #(
    .W (WIDTH + 1)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .in_vld_i  (cmp_vld),
    .in_dat_i  ({cmp_err, cmp_word}),
    .out_dat_o ({out_err, out_word}),
    .out_vld_o (dout_vld),
    .out_rdy_i (dout_rdy),
    .ovf_o     (ovf)
  );

  assign dout     = out_word;
  assign dout_err = PARITY_EN ? out_err : 1'b0;

endmodule

// File: tb/tb_s2p_stream.sv
// tb_s2p_stream: directed bench for s2p_stream (LSB-first and MSB-first instances in parallel).
// Inputs are driven and outputs sampled on the falling clock edge.
// Honours S2P_PARITY_EN: a parity bit is appended to each word when the macro is defined.
module tb_s2p_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       din, din_vld, din_sof, dout_rdy;
  logic [9:0] dout, dout_m;
  logic       dout_vld, dout_vld_m, dout_err, dout_err_m, ovf, ovf_m;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;
  int vld_cnt = 0;

  always #5 clk = ~clk;

  s2p_stream #(.WIDTH(10), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_sof(din_sof),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .dout_err(dout_err), .ovf(ovf)
  );

  s2p_stream #(.WIDTH(10), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_sof(din_sof),
    .dout(dout_m), .dout_vld(dout_vld_m), .dout_rdy(dout_rdy), .dout_err(dout_err_m), .ovf(ovf_m)
  );

  always @(negedge clk) begin
    if (ovf === 1'b1) ovf_cnt++;
    if (dout_vld === 1'b1) vld_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic sof);
    din     = b;
    din_vld = 1'b1;
    din_sof = sof;
    @(negedge clk);
    din     = 1'b0;
    din_vld = 1'b0;
    din_sof = 1'b0;
  endtask

  // s[i] is the i-th bit on the wire; random idle gaps of 0..gap_max between bits.
  task automatic send_word(input logic [9:0] s, input logic sof, input int gap_max,
                           input logic par_flip);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      send_bit(s[i], sof && (i == 0));
    end
`ifdef S2P_PARITY_EN
    repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    send_bit((^s) ^ par_flip, 1'b0);
`else
    if (par_flip) $display("note: parity flip ignored without parity");
`endif
  endtask

  typedef struct {
    logic [9:0] stream;
    logic [9:0] exp_lsb;
    logic [9:0] exp_msb;
  } vec_t;

  vec_t vecs[5];
  logic [9:0] w3[3];
  int snap;

  initial begin
    vecs[0] = '{10'h20D, 10'h20D, 10'h2C1};
    vecs[1] = '{10'h3FF, 10'h3FF, 10'h3FF};
    vecs[2] = '{10'h001, 10'h001, 10'h200};
    vecs[3] = '{10'h155, 10'h155, 10'h2AA};
    vecs[4] = '{10'h0F0, 10'h0F0, 10'h03C};
    w3[0] = 10'h12C; w3[1] = 10'h2B3; w3[2] = 10'h3C5;

    rst = 1'b1; din = 1'b0; din_vld = 1'b0; din_sof = 1'b0; dout_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_vld", 32'(dout_vld), 32'h0);
    chk("rst_err", 32'(dout_err), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;
    // Bits without sof are ignored from IDLE.
    snap = vld_cnt;
    send_word(10'h3FF, 1'b0, 0, 1'b0);
    chk("idle_ignore", 32'(vld_cnt - snap), 32'h0);

    // Table vectors, dout_rdy=1.
    for (int v = 0; v < 5; v++) begin
      send_word(vecs[v].stream, 1'b1, 0, 1'b0);
      chk("vec_vld", 32'(dout_vld), 32'h1);
      chk("vec_lsb", 32'(dout), 32'(vecs[v].exp_lsb));
      chk("vec_msb", 32'(dout_m), 32'(vecs[v].exp_msb));
      chk("vec_err", 32'(dout_err), 32'h0);
      chk("vec_ovf", 32'(ovf), 32'h0);
      @(negedge clk);
      chk("vec_vld_drop", 32'(dout_vld), 32'h0);
    end

    // Three words back-to-back with gaps; only the first carries sof.
    snap = ovf_cnt;
    for (int k = 0; k < 3; k++) begin
      send_word(w3[k], k == 0, 3, 1'b0);
      chk("b2b_vld", 32'(dout_vld), 32'h1);
      chk("b2b_dout", 32'(dout), 32'(w3[k]));
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    chk("b2b_no_ovf", 32'(ovf_cnt - snap), 32'h0);

    // Backpressure: second word dropped, first held.
    @(negedge clk);
    dout_rdy = 1'b0;
    snap = ovf_cnt;
    send_word(10'h0F0, 1'b1, 0, 1'b0);
    chk("bp_vld_a", 32'(dout_vld), 32'h1);
    chk("bp_dout_a", 32'(dout), 32'h0F0);
    send_word(10'h3FF, 1'b0, 1, 1'b0);
    chk("bp_ovf_pulse", 32'(ovf), 32'h1);
    chk("bp_hold", 32'(dout), 32'h0F0);
    @(negedge clk);
    chk("bp_ovf_end", 32'(ovf), 32'h0);
    chk("bp_ovf_once", 32'(ovf_cnt - snap), 32'h1);
    chk("bp_hold2", 32'(dout), 32'h0F0);
    chk("bp_vld_hold", 32'(dout_vld), 32'h1);
    dout_rdy = 1'b1;
    @(negedge clk);
    chk("bp_consumed", 32'(dout_vld), 32'h0);

    // sof reasserted at bit 6: partial discarded.
    for (int i = 0; i < 6; i++) send_bit(1'b1, i == 0);
    chk("resync_no_vld", 32'(dout_vld), 32'h0);
    send_word(10'h155, 1'b1, 0, 1'b0);
    chk("resync_vld", 32'(dout_vld), 32'h1);
    chk("resync_lsb", 32'(dout), 32'h155);
    chk("resync_msb", 32'(dout_m), 32'h2AA);
    @(negedge clk);

    // Reset at bit 4: no output, bits ignored until sof.
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    snap = vld_cnt;
    send_word(10'h20D, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("rst_mid_no_vld", 32'(vld_cnt - snap), 32'h0);
    chk("rst_mid_dout", 32'(dout), 32'h0);
    send_word(10'h20D, 1'b1, 0, 1'b0);
    chk("rst_mid_recover", 32'(dout), 32'h20D);
    @(negedge clk);

    // Reset with a pending word discards it.
    dout_rdy = 1'b0;
    send_word(10'h001, 1'b1, 0, 1'b0);
    chk("pend_vld", 32'(dout_vld), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("pend_drop_vld", 32'(dout_vld), 32'h0);
    chk("pend_drop_dout", 32'(dout), 32'h0);
    dout_rdy = 1'b1;

`ifdef S2P_PARITY_EN
    send_word(10'h20D, 1'b1, 0, 1'b0);
    chk("par_ok_vld", 32'(dout_vld), 32'h1);
    chk("par_ok_err", 32'(dout_err), 32'h0);
    @(negedge clk);
    send_word(10'h20D, 1'b0, 0, 1'b1);
    chk("par_bad_vld", 32'(dout_vld), 32'h1);
    chk("par_bad_dout", 32'(dout), 32'h20D);
    chk("par_bad_err", 32'(dout_err), 32'h1);
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
